// File: rtl/count_capture.sv
// count_capture: synchronises an event line, and on each rising edge stores the current count
// in a first-word-fall-through FIFO that drains over valid/ready. Sticky overflow marks dropped events.
// Optional per-drop saturating counter on port drop_cnt: define COUNT_CAPTURE_DROP_CNT_EN.
module count_capture #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4   // power of 2, >= 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           count,
    input  logic                       enable,
    input  logic                       event_in,
    output logic [WIDTH-1:0]           m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
`ifdef COUNT_CAPTURE_DROP_CNT_EN
    output logic [7:0]                 drop_cnt,
`endif
    input  logic                       ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic             s1, s2, s3;
    logic             evt_edge;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic             empty, full, pop, push, drop;

    // s1/s2 form the synchroniser; s3 remembers the previous s2 for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= event_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign evt_edge = s2 & ~s3;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = m_valid & m_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts the write.
    assign push  = evt_edge & enable & (~full | pop);
    assign drop  = evt_edge & enable & full & ~pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is deliberately left unreset; contents are only observed while m_valid is high.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= count;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)       overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

`ifdef COUNT_CAPTURE_DROP_CNT_EN
    // Drop wins over clear; a drop coinciding with a clear restarts the count at 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt <= 8'd0;
        end else if (drop) begin
            if (ovf_clr)                 drop_cnt <= 8'd1;
            else if (drop_cnt != 8'hFF)  drop_cnt <= drop_cnt + 8'd1;
        end else if (ovf_clr) begin
            drop_cnt <= 8'd0;
        end
    end
`endif

    assign m_valid = ~empty;
    assign m_data  = mem[rd_ptr[AW-1:0]];
    assign level   = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_count_capture.sv
// Self-checking bench for count_capture: directed scenarios plus randomized traffic
// against a queue-based model of the capture/FIFO behaviour.
module tb_count_capture;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] count = '0;
    logic             enable = 1'b0;
    logic             event_in = 1'b0;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [LW-1:0]    level;
    logic             overflow;
    logic             ovf_clr = 1'b0;
`ifdef COUNT_CAPTURE_DROP_CNT_EN
    logic [7:0]       drop_cnt;
`endif

    count_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .count(count), .enable(enable), .event_in(event_in),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .level(level),
        .overflow(overflow),
`ifdef COUNT_CAPTURE_DROP_CNT_EN
        .drop_cnt(drop_cnt),
`endif
        .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference model: event samples from the last three clock edges, a queue of stored counts.
    bit               h1, h2, h3;
    logic [WIDTH-1:0] q[$];
    bit               m_ovf;
    int               m_dcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit ev, fire, do_pop, drop;
        if (!rst_n) begin
            h1 = 0; h2 = 0; h3 = 0;
            q.delete();
            m_ovf = 0;
            m_dcnt = 0;
            return;
        end
        // A rising edge is recognised when the event was seen two edges ago but not three.
        ev     = h2 && !h3;
        fire   = ev && enable;
        do_pop = (q.size() > 0) && m_ready;
        drop   = fire && (q.size() == DEPTH) && !do_pop;
        if (do_pop) void'(q.pop_front());
        if (fire && !drop) q.push_back(count);
        if (drop) begin
            m_ovf  = 1;
            m_dcnt = ovf_clr ? 1 : (m_dcnt < 255 ? m_dcnt + 1 : 255);
        end else if (ovf_clr) begin
            m_ovf  = 0;
            m_dcnt = 0;
        end
        h3 = h2; h2 = h1; h1 = event_in;
    endtask

    task automatic check_model();
        chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
        chk("level", 32'(level), 32'(q.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (q.size() != 0) chk("m_data", 32'(m_data), 32'(q[0]));
`ifdef COUNT_CAPTURE_DROP_CNT_EN
        chk("drop_cnt", 32'(drop_cnt), 32'(m_dcnt));
`endif
    endtask

    // Inputs change only at the negedge; the model sees them at the posedge together with the DUT.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_event();
        event_in = 1'b1;
        count = WIDTH'($urandom);
        step();
        event_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            count = WIDTH'($urandom);
            step();
        end
    endtask

    initial begin
        @(negedge clk);
        rst_n = 1'b0;
        steps(2);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        enable = 1'b1;

        // Single capture: count equals the index of the edge it is presented to.
        for (int e = 1; e <= 12; e++) begin
            count = WIDTH'(e);
            if (e == 10) event_in = 1'b1;
            step();
            if (e == 11) chk("single_early", 32'(m_valid), 32'd0);
        end
        chk("single_valid", 32'(m_valid), 32'd1);
        chk("single_data", 32'(m_data), 32'd12);
        chk("single_level", 32'(level), 32'd1);

        // Held level: one entry only, despite event_in staying high.
        event_in = 1'b0;
        m_ready = 1'b1;
        steps(5);
        m_ready = 1'b0;
        event_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            count = WIDTH'($urandom);
            step();
        end
        chk("held_level", 32'(level), 32'd1);
        event_in = 1'b0;
        m_ready = 1'b1;
        steps(5);
        m_ready = 1'b0;

        // Overflow: five separated events into a four-deep FIFO.
        for (int i = 0; i < 5; i++) pulse_event();
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
`ifdef COUNT_CAPTURE_DROP_CNT_EN
        chk("ovf_dcnt", 32'(drop_cnt), 32'd1);
`endif
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("clr_flag", 32'(overflow), 32'd0);

        // Full with a pop in the same cycle as the edge: write accepted, no overflow.
        event_in = 1'b1;
        count = WIDTH'($urandom);
        step();
        event_in = 1'b0;
        step();
        m_ready = 1'b1;
        count = WIDTH'($urandom);
        step();
        m_ready = 1'b0;
        chk("fullpop_level", 32'(level), 32'd4);
        chk("fullpop_ovf", 32'(overflow), 32'd0);

        // Events with enable low leave the FIFO and flag alone.
        enable = 1'b0;
        for (int i = 0; i < 3; i++) pulse_event();
        chk("dis_level", 32'(level), 32'd4);
        chk("dis_ovf", 32'(overflow), 32'd0);
        enable = 1'b1;

        // Reset mid-operation with level 3 and overflow set.
        pulse_event();
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("pre_rst_level", 32'(level), 32'd3);
        chk("pre_rst_ovf", 32'(overflow), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        pulse_event();
        chk("post_rst_level", 32'(level), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            count    = WIDTH'($urandom);
            if ($urandom_range(0, 3) == 0) event_in = ~event_in;
            m_ready  = ($urandom_range(0, 3) == 0);
            enable   = ($urandom_range(0, 7) != 0);
            ovf_clr  = ($urandom_range(0, 15) == 0);
            rst_n    = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
